// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Fetch-stage instruction buffer. A slot is reserved when an imem
//            request issues (PC written then), the instruction lands when the
//            in-order response returns, and dispatch drains filled head
//            entries through a valid/ready handshake. A flush empties the
//            buffer and arranges for in-flight responses to be dropped.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH  = 8,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       req_valid,
  input  logic [PC_W-1:0]            req_pc,
  output logic                       req_ready,
  input  logic                       imem_resp,
  input  logic [INST_W-1:0]          imem_rdata,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [PC_W-1:0]            deq_pc,
  output logic [INST_W-1:0]          deq_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_SUM_W = c_CNT_W + 1;

  // Pointers carry a wrap bit so full and empty are distinguishable.
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_fill;
  logic [c_PTR_W-1:0] r_alloc;
  logic [c_CNT_W-1:0] r_drop;
  logic [DEPTH-1:0]   r_filled;
  logic [PC_W-1:0]    r_pc   [DEPTH];
  logic [INST_W-1:0]  r_inst [DEPTH];

  logic [c_IDX_W-1:0] w_head_idx;
  logic [c_IDX_W-1:0] w_fill_idx;
  logic [c_IDX_W-1:0] w_alloc_idx;
  logic [c_PTR_W-1:0] w_unfilled;
  logic [c_PTR_W-1:0] w_count;
  logic [c_SUM_W-1:0] w_outstanding;
  logic [c_SUM_W-1:0] w_drop_flush;
  logic               w_full;
  logic               w_alloc;
  logic               w_fill;
  logic               w_deq;

  assign w_head_idx  = r_head[c_IDX_W-1:0];
  assign w_fill_idx  = r_fill[c_IDX_W-1:0];
  assign w_alloc_idx = r_alloc[c_IDX_W-1:0];

  assign w_unfilled    = r_alloc - r_fill;
  assign w_count       = r_alloc - r_head;
  assign w_full        = (w_count == c_PTR_W'(DEPTH));
  // Responses still owed by imem: stale ones to drop plus live unfilled slots.
  assign w_outstanding = c_SUM_W'(r_drop) + c_SUM_W'(w_unfilled);

  // A response in the flush cycle is consumed regardless of its epoch; the
  // zero guard only matters for a protocol-violating response.
  assign w_drop_flush  = (imem_resp && (w_outstanding != '0))
                         ? (w_outstanding - c_SUM_W'(1)) : w_outstanding;

  // rst gating keeps req_ready low for the whole time reset is asserted.
  assign req_ready = rst && !flush && !w_full && (w_outstanding < c_SUM_W'(DEPTH));
  assign deq_valid = (w_count != '0) && r_filled[w_head_idx];
  assign deq_pc    = r_pc[w_head_idx];
  assign deq_inst  = r_inst[w_head_idx];
  assign count     = c_CNT_W'(w_count);

  assign w_alloc = req_valid && req_ready;
  assign w_fill  = imem_resp && !flush && (r_drop == '0) && (w_unfilled != '0);
  assign w_deq   = deq_valid && deq_ready && !flush;

  // Pointer, drop counter and filled-bit bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_fill   <= '0;
      r_alloc  <= '0;
      r_drop   <= '0;
      r_filled <= '0;
    end else if (flush) begin
      r_head   <= '0;
      r_fill   <= '0;
      r_alloc  <= '0;
      r_filled <= '0;
      r_drop   <= c_CNT_W'(w_drop_flush);
    end else begin
      // Alloc, fill and head indices never collide when their actions fire.
      if (w_alloc) begin
        r_filled[w_alloc_idx] <= 1'b0;
        r_alloc               <= r_alloc + c_PTR_W'(1);
      end
      if (imem_resp && (r_drop != '0)) begin
        r_drop <= r_drop - c_CNT_W'(1);
      end
      if (w_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_fill               <= r_fill + c_PTR_W'(1);
      end
      if (w_deq) begin
        r_filled[w_head_idx] <= 1'b0;
        r_head               <= r_head + c_PTR_W'(1);
      end
    end
  end

  // Payload storage; contents are qualified by the filled bits, so no reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_pc[w_alloc_idx] <= req_pc;
    end
    if (w_fill) begin
      r_inst[w_fill_idx] <= imem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Randomised bench for fetch_buffer with an in-order imem model,
//            a queue-based reference of buffer occupancy and a dequeue
//            scoreboard checked by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  localparam int DEPTH  = 8;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              req_valid;
  logic [PC_W-1:0]   req_pc;
  logic              req_ready;
  logic              imem_resp;
  logic [INST_W-1:0] imem_rdata;
  logic              deq_ready;
  logic              deq_valid;
  logic [PC_W-1:0]   deq_pc;
  logic [INST_W-1:0] deq_inst;
  logic [CW-1:0]     count;

  fetch_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .deq_ready(deq_ready), .deq_valid(deq_valid),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .count(count)
  );

  always #5 clk = ~clk;

  // Reference state: allocated entries in order, stale responses owed,
  // requests outstanding at imem, and expected dispatch stream.
  typedef struct { logic [31:0] pc; bit filled; } ent_t;
  typedef struct { logic [31:0] pc; int cyc; }    req_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  ent_t mq [$];
  req_t imq[$];
  exp_t sbq[$];
  int   m_drop = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] pc_next = 32'h0;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return (pc * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted dequeue must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && deq_valid === 1'b1 && deq_ready === 1'b1 && flush === 1'b0) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL deq_unexpected: got pc %h expected no dispatch (cycle %0d)", deq_pc, cyc);
        end else begin
          e = sbq.pop_front();
          check("deq_pc", deq_pc, e.pc);
          check("deq_inst", deq_inst, e.inst);
        end
      end
    end
  end

  // One cycle of stimulus, expectation check and reference update.
  task automatic step(input int p_req, input int p_deq, input int p_resp, input int p_flush);
    int  unf;
    bit  e_rr, e_dv, req_fire, deq_fire, resp;
    logic [31:0] pc_now;
    ent_t t;
    @(posedge clk);
    #1;
    cyc++;
    flush     = ($urandom_range(99) < p_flush);
    req_valid = ($urandom_range(99) < p_req);
    pc_now    = pc_next;
    req_pc    = pc_now;
    deq_ready = ($urandom_range(99) < p_deq);
    resp      = (imq.size() > 0) && (imq[0].cyc < cyc) && ($urandom_range(99) < p_resp);
    imem_resp = resp;
    imem_rdata = resp ? inst_of(imq[0].pc) : $urandom;

    unf = 0;
    foreach (mq[i]) if (!mq[i].filled) unf++;
    e_rr = !flush && (mq.size() < DEPTH) && (m_drop + unf < DEPTH);
    e_dv = (mq.size() > 0) && mq[0].filled;
    req_fire = req_valid && e_rr;
    deq_fire = e_dv && deq_ready && !flush;

    if (flush) sbq.delete();
    else if (req_fire) sbq.push_back('{pc_now, inst_of(pc_now)});

    #3;
    check("req_ready", 32'(req_ready), 32'(e_rr));
    check("deq_valid", 32'(deq_valid), 32'(e_dv));
    check("count", 32'(count), mq.size());

    if (resp) void'(imq.pop_front());
    if (flush) begin
      m_drop = m_drop + unf - (resp ? 1 : 0);
      mq.delete();
      pc_next = 32'h100 + ($urandom_range(255) << 2);
    end else begin
      if (resp) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled) begin
              t = mq[i];
              t.filled = 1'b1;
              mq[i] = t;
              break;
            end
          end
        end
      end
      if (deq_fire) void'(mq.pop_front());
      if (req_fire) begin
        mq.push_back('{pc_now, 1'b0});
        imq.push_back('{pc_now, cyc});
        pc_next = pc_now + 32'd4;
      end
    end
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic mid_reset();
    @(posedge clk);
    #1;
    flush = 1'b0; req_valid = 1'b0; deq_ready = 1'b0; imem_resp = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    mq.delete(); imq.delete(); sbq.delete();
    m_drop = 0;
    pc_next = 32'h0;
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // Phases: {p_req, p_deq, p_resp, p_flush, cycles}
  int ph [9][5] = '{
    '{100, 100, 100,   0,   60},  // streaming
    '{100,   0, 100,   0,   30},  // full stall
    '{100, 100, 100,   0,   20},  // drain
    '{100,   0,   0,   0,   12},  // imem silent, slots unfilled
    '{  0,   0, 100, 100,    1},  // flush with response in flight
    '{100,  50,   0,   0,    6},  // outstanding bound
    '{100,  80,  60,   0,   40},  // drops then refill
    '{ 70,  60,  50,   4, 1500},  // mixed with flushes
    '{ 90,  90,  30,   8, 1500}   // slow imem, frequent flushes
  };

  initial begin
    rst = 1'b0; flush = 1'b0; req_valid = 1'b0; req_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0; deq_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_deq_valid", 32'(deq_valid), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("release_req_ready", 32'(req_ready), 32'd1);

    for (int p = 0; p < 9; p++) begin
      for (int c = 0; c < ph[p][4]; c++) step(ph[p][0], ph[p][1], ph[p][2], ph[p][3]);
      if (p == 1 || p == 7) mid_reset();
    end
    // Let everything drain so the scoreboard is exercised to the end.
    for (int c = 0; c < 60; c++) step(0, 100, 100, 0);
    check("scoreboard_empty", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_buffer.md
# fetch_buffer

Parametrised fetch-stage instruction buffer that sits between the fetch-1 PC stage, instruction memory and decode/dispatch. It fixes the lost-instruction hazard of a push/pop-only queue by reserving a slot when each imem request is issued. The slot's PC is written at request time and its instruction when the in-order imem response arrives. On a mispredict it flushes all entries and silently drops the responses still in flight. Dispatch drains it through a valid/ready handshake.

## Interface
- DEPTH, 8, number of entries; power of two, at least 2
- PC_W, 32, PC width
- INST_W, 32, instruction width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  branch mispredict; discard all buffered and in-flight instructions
- req_valid  in  1  fetch-1 presents a PC to fetch
- req_pc  in  PC_W  PC of the request
- req_ready  out  1  request may issue to imem this cycle; a handshake allocates a slot
- imem_resp  in  1  imem returns one instruction, in request order
- imem_rdata  in  INST_W  returned instruction
- deq_ready  in  1  dispatch can accept (not reservation-station full and not ROB full)
- deq_valid  out  1  head entry holds a filled instruction
- deq_pc  out  PC_W  head PC
- deq_inst  out  INST_W  head instruction
- count  out  $clog2(DEPTH+1)  allocated entries, filled plus unfilled

## Operation
- Storage: DEPTH entries, each holding {pc, inst, filled}.
- Three pointers, each $clog2(DEPTH)+1 bits wide with a wrap bit:
  - head: next entry to dequeue.
  - fill: next entry awaiting a response.
  - alloc: next entry to allocate.
  - Invariant: head ≤ fill ≤ alloc, modulo wrap.
- Derived quantities:
  - unfilled = alloc − fill.
  - count = alloc − head.
  - full when count == DEPTH.
- drop_cnt, $clog2(DEPTH+1) bits: responses still to be discarded from the pre-flush epoch.
- req_ready = !flush && !full && (drop_cnt + unfilled < DEPTH). This bounds total imem outstanding to DEPTH.
- Allocate: on req_valid && req_ready, write entry[alloc].pc = req_pc, clear filled, alloc++.
- Response handling, when imem_resp && !flush:
  - If drop_cnt > 0: discard the data and decrement drop_cnt.
  - Else if unfilled > 0: write entry[fill].inst, set filled, fill++.
  - Else: protocol violation. The response is ignored and the bench asserts.
- Dequeue:
  - deq_valid = (count > 0) && entry[head].filled.
  - On deq_valid && deq_ready: head++ and clear filled.
- Flush, synchronous on the edge where flush is high:
  - head = fill = alloc = 0; all filled bits cleared.
  - drop_cnt_next = drop_cnt + unfilled − (imem_resp ? 1 : 0). A response in the flush cycle is discarded whichever epoch it belongs to.
  - No allocate or dequeue takes effect that cycle.
- Allocate, fill and dequeue may all occur in the same cycle; all three updates apply independently.
- Outputs are registered-state driven. deq_pc and deq_inst are don't-care when deq_valid = 0.

## Timing
- Reset (rst = 0, asynchronous):
  - All pointers, drop_cnt and filled bits cleared.
  - deq_valid = 0, count = 0, req_ready = 0 while rst is low.
  - After release, req_ready = 1 if flush = 0.
- Request to response: imem latency ≥ 1 cycle; no fixed latency is assumed.
- Fill to dispatch: a response at edge t makes deq_valid = 1 in cycle t+1 if that entry is the head. There is no same-cycle bypass.
- No combinational path deq_ready → req_ready. A slot freed by dequeue at edge t is allocatable from cycle t+1.
- Full: req_ready = 0 until a dequeue. Responses continue filling while full.
- Wrap: pointer wrap bits distinguish full from empty. Entry index is the pointer modulo DEPTH.
- Back-to-back flushes accumulate drop_cnt. Requests may issue while drop_cnt > 0, subject to the outstanding bound.
- Reset mid-operation discards everything, including drop_cnt. The imem is reset in the same domain.

## Test plan
- Streaming, DEPTH=8, deq_ready=1: requests PC 0x00, 0x04, … with 1-cycle imem latency → deq_pc/deq_inst emerge in order, one per cycle after a 2-cycle fill latency, and count stays ≤ 2.
- Full stall, deq_ready=0: 8 requests accepted, then req_ready=0 and count=8. After all 8 responses, deq_valid=1. Raising deq_ready for one cycle gives req_ready=1 the next cycle.
- Flush with 3 unfilled entries and imem_resp in the flush cycle → count=0 and drop_cnt=2. The next 2 responses are discarded. A new request to PC 0x100 is then filled, and dispatch sees 0x100 only.
- Out-of-order-free fill, head unfilled: 3 requests, responses delayed 5 cycles → deq_valid stays 0 until the first response, then the three entries dequeue in request order.
- Outstanding bound: drop_cnt=6 after a flush with DEPTH=8 → exactly 2 new requests accepted, then req_ready=0 until a drop occurs.
- Asynchronous reset asserted mid-stream, between clock edges → deq_valid and count go to 0 immediately. After release, operation restarts cleanly with no stale data.
